// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Anode vectors are active-low; nibble i of a display word belongs to digit i.
package ssd_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int NIB_W      = 4;
  localparam int WORD_W     = NUM_DIGITS * NIB_W;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  function automatic logic [NUM_DIGITS-1:0] onehot_an(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1'b1) << idx);
  endfunction

  // Digit idx (idx >= 1) is blanked when it and every digit to its left hold zero.
  function automatic logic lz_blank(input logic [WORD_W-1:0] word, input logic [IDX_W-1:0] idx);
    logic blank;
    blank = (idx != IDX_W'(0));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (word[i*NIB_W +: NIB_W] != NIB_W'(0))) begin
        blank = 1'b0;
      end else begin
        blank = blank;
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/ssd_refresh_div.sv
// Slot counter for the display scan: counts 0..REFRESH_DIV-1, flags the last
// cycle of a slot (tick) and the leading guard cycles of a slot (in_guard).
module ssd_refresh_div #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic in_guard
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_r;

  // Slot counter register, wraps after the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_W'(0);
    end else if (tick) begin
      cnt_r <= CNT_W'(0);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Slot-end and guard-window decode.
  always_comb begin
    tick     = (cnt_r == CNT_W'(REFRESH_DIV - 1));
    in_guard = (cnt_r < CNT_W'(GUARD_CYC));
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Eight-digit multiplexed scan controller with frame-synchronous double-buffered
// updates, leading-zero blanking and an all-dark guard at the start of each slot.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4
) (
  input  logic                  ssd_scan_ctrl_port_clk,
  input  logic                  ssd_scan_ctrl_port_rst_n,
  input  logic [WORD_W-1:0]     ssd_scan_ctrl_port_value,
  input  logic [NUM_DIGITS-1:0] ssd_scan_ctrl_port_dp_mask,
  input  logic                  ssd_scan_ctrl_port_upd_req,
  output logic                  ssd_scan_ctrl_port_upd_ack,
  input  logic [NUM_DIGITS-1:0] ssd_scan_ctrl_port_digit_en,
  input  logic                  ssd_scan_ctrl_port_lz_en,
  output logic [NIB_W-1:0]      ssd_scan_ctrl_port_nibble,
  output logic                  ssd_scan_ctrl_port_dp,
  output logic [NUM_DIGITS-1:0] ssd_scan_ctrl_port_an,
  output logic                  ssd_scan_ctrl_port_frame_start
);

  logic                  tick_s;
  logic                  in_guard_s;
  logic                  wrap_s;
  logic                  commit_s;
  logic                  dark_s;
  logic [NUM_DIGITS-1:0] an_s;
  logic [IDX_W-1:0]      idx_r;
  logic [WORD_W-1:0]     disp_r;
  logic [WORD_W-1:0]     stage_r;
  logic [NUM_DIGITS-1:0] disp_dp_r;
  logic [NUM_DIGITS-1:0] stage_dp_r;
  logic                  pending_r;

  ssd_refresh_div #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYC   (GUARD_CYC)
  ) u_refresh_div (
    .clk      (ssd_scan_ctrl_port_clk),
    .rst_n    (ssd_scan_ctrl_port_rst_n),
    .tick     (tick_s),
    .in_guard (in_guard_s)
  );

  // Frame-wrap/commit decode and anode selection for the current digit.
  always_comb begin
    an_s     = AN_OFF;
    wrap_s   = tick_s && (idx_r == IDX_W'(NUM_DIGITS - 1));
    commit_s = wrap_s && pending_r;
    dark_s   = !ssd_scan_ctrl_port_digit_en[idx_r] ||
               (ssd_scan_ctrl_port_lz_en && lz_blank(disp_r, idx_r));
    if (in_guard_s || dark_s) begin
      an_s = AN_OFF;
    end else begin
      an_s = onehot_an(idx_r);
    end
  end

  // Digit index, staging/display buffers and pending flag.
  always_ff @(posedge ssd_scan_ctrl_port_clk) begin
    if (!ssd_scan_ctrl_port_rst_n) begin
      idx_r      <= IDX_W'(0);
      disp_r     <= WORD_W'(0);
      stage_r    <= WORD_W'(0);
      disp_dp_r  <= NUM_DIGITS'(0);
      stage_dp_r <= NUM_DIGITS'(0);
      pending_r  <= 1'b0;
    end else begin
      if (tick_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (ssd_scan_ctrl_port_upd_req) begin
        stage_r    <= ssd_scan_ctrl_port_value;
        stage_dp_r <= ssd_scan_ctrl_port_dp_mask;
      end
      // A commit takes the pre-edge staging contents; a coincident request re-arms pending.
      if (commit_s) begin
        disp_r    <= stage_r;
        disp_dp_r <= stage_dp_r;
      end
      pending_r <= ssd_scan_ctrl_port_upd_req | (pending_r & ~commit_s);
    end
  end

  // Registered outputs toward the anode drivers and the segment decoder.
  always_ff @(posedge ssd_scan_ctrl_port_clk) begin
    if (!ssd_scan_ctrl_port_rst_n) begin
      ssd_scan_ctrl_port_an          <= AN_OFF;
      ssd_scan_ctrl_port_nibble      <= NIB_W'(0);
      ssd_scan_ctrl_port_dp          <= 1'b0;
      ssd_scan_ctrl_port_upd_ack     <= 1'b0;
      ssd_scan_ctrl_port_frame_start <= 1'b0;
    end else begin
      ssd_scan_ctrl_port_an          <= an_s;
      ssd_scan_ctrl_port_nibble      <= disp_r[{idx_r, 2'b00} +: NIB_W];
      ssd_scan_ctrl_port_dp          <= disp_dp_r[idx_r];
      ssd_scan_ctrl_port_upd_ack     <= commit_s;
      ssd_scan_ctrl_port_frame_start <= wrap_s;
    end
  end

endmodule
